// File: rtl/casca_pkg.sv
// Shared types and constants for the switch-to-mode front end.
package casca_pkg;

  localparam int N_SW   = 10;
  localparam int MODE_W = 4;
  localparam logic [MODE_W-1:0] MODE_NONE = 4'hA;

  typedef enum logic [1:0] {
    NONE,
    SETTLE,
    ACTIVE,
    LOCKED
  } state_t;

  // Index of the highest set switch; MODE_NONE when no switch is on.
  function automatic logic [MODE_W-1:0] prio_encode(input logic [N_SW-1:0] sw);
    logic [MODE_W-1:0] r;
    r = MODE_NONE;
    for (int i = 0; i < N_SW; i++) begin
      if (sw[i]) r = MODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-FF synchroniser followed by a consecutive-disagreement debounce counter.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seletor_modo.sv
// Switch debouncing, priority encoding and settle-then-commit mode FSM.
// Optional feature: SAFE_INTERLOCK_EN forces an all-off pass between two different modes.
module seletor_modo
  import casca_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_SW-1:0]   sw_db,
  output logic [MODE_W-1:0] mode,
  output logic              mode_valid,
  output logic              mode_chg,
  output logic              interlock
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYCLES - 1);

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk(clk_50MHz),
      .rst(rst),
      .raw(sw_raw[i]),
      .db (sw_db[i])
    );
  end

  logic [MODE_W-1:0] cand;
  assign cand = prio_encode(sw_db);

  state_t            state,    state_nx;
  logic [MODE_W-1:0] cand_reg, cand_reg_nx;
  logic [SCNT_W-1:0] scnt,     scnt_nx;
  logic [MODE_W-1:0] mode_nx;
  logic              mode_chg_nx;
`ifdef SAFE_INTERLOCK_EN
  logic              lock_q,   lock_nx;
`endif

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    cand_reg_nx = cand_reg;
    scnt_nx     = scnt;
    mode_nx     = mode;
    mode_chg_nx = 1'b0;
`ifdef SAFE_INTERLOCK_EN
    lock_nx     = lock_q;
`endif
    // All-off wins over every other transition and never waits for settle.
    if (cand == MODE_NONE) begin
      state_nx    = NONE;
      mode_nx     = MODE_NONE;
      mode_chg_nx = (mode != MODE_NONE);
`ifdef SAFE_INTERLOCK_EN
      lock_nx     = 1'b0;
`endif
    end else begin
      case (state)
        NONE: begin
          state_nx    = SETTLE;
          cand_reg_nx = cand;
          scnt_nx     = '0;
        end
        SETTLE: begin
          if (cand != cand_reg) begin
            cand_reg_nx = cand;
            scnt_nx     = '0;
          end else if (scnt == SCNT_LAST) begin
            state_nx    = ACTIVE;
            mode_nx     = cand_reg;
            mode_chg_nx = (cand_reg != mode);
          end else begin
            scnt_nx = scnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (cand != mode) begin
`ifdef SAFE_INTERLOCK_EN
            state_nx    = LOCKED;
            mode_nx     = MODE_NONE;
            mode_chg_nx = 1'b1;
            lock_nx     = 1'b1;
`else
            state_nx    = SETTLE;
            cand_reg_nx = cand;
            scnt_nx     = '0;
`endif
          end
        end
`ifdef SAFE_INTERLOCK_EN
        LOCKED: begin
          state_nx = LOCKED;
        end
`endif
        default: begin
          state_nx = NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state      <= NONE;
      cand_reg   <= MODE_NONE;
      scnt       <= '0;
      mode       <= MODE_NONE;
      mode_valid <= 1'b0;
      mode_chg   <= 1'b0;
`ifdef SAFE_INTERLOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cand_reg   <= cand_reg_nx;
      scnt       <= scnt_nx;
      mode       <= mode_nx;
      mode_valid <= (mode_nx != MODE_NONE);
      mode_chg   <= mode_chg_nx;
`ifdef SAFE_INTERLOCK_EN
      lock_q     <= lock_nx;
`endif
    end
  end

`ifdef SAFE_INTERLOCK_EN
  assign interlock = lock_q;
`else
  assign interlock = 1'b0;
`endif

endmodule

// File: tb/tb_seletor_modo.sv
// Directed bench for seletor_modo with DEBOUNCE_CYCLES=8, SETTLE_CYCLES=4 (latency 15 cycles).
module tb_seletor_modo;

`ifdef SAFE_INTERLOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk_50MHz = 1'b0;
  logic       rst;
  logic [9:0] sw_raw;
  logic [9:0] sw_db;
  logic [3:0] mode;
  logic       mode_valid;
  logic       mode_chg;
  logic       interlock;

  seletor_modo #(
    .DEBOUNCE_CYCLES(8),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .mode      (mode),
    .mode_valid(mode_valid),
    .mode_chg  (mode_chg),
    .interlock (interlock)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int checks = 0;
  int errors = 0;
  int chg_seen = 0;
  logic prev_chg = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One clock: advance past the rising edge, sample on the falling edge.
  task automatic tick();
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    if (mode_chg) begin
      chg_seen++;
      check("chg_back_to_back", {31'd0, prev_chg}, 32'd0);
    end
    prev_chg = mode_chg;
  endtask

  typedef struct {
    logic [9:0] sw;
    int         cycles;
    logic [9:0] db;
    logic [3:0] mode;
    logic       valid;
    logic       lock;
    int         chg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int db_edge, md_edge, chg_edge, bad, c0;

    rst    = 1'b1;
    sw_raw = 10'h000;
    #35;
    check("rst_mode", {28'd0, mode}, 32'hA);
    check("rst_valid", {31'd0, mode_valid}, 32'd0);
    check("rst_chg", {31'd0, mode_chg}, 32'd0);
    check("rst_sw_db", {22'd0, sw_db}, 32'd0);
    check("rst_interlock", {31'd0, interlock}, 32'd0);
    @(negedge clk_50MHz);
    rst = 1'b0;

    // 1: idle for 100 cycles, outputs must stay at reset values
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sw_db != 10'h000 || mode != 4'hA || mode_valid || mode_chg || interlock) bad++;
    end
    check("t1_idle_bad_cycles", bad, 0);

    // 2: SW9 on; sw_db at edge 10, mode at edge 15, one pulse
    sw_raw = 10'h200;
    db_edge = -1; md_edge = -1; chg_edge = -1; c0 = chg_seen;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (db_edge < 0 && sw_db[9]) db_edge = e;
      if (md_edge < 0 && mode == 4'd9) md_edge = e;
      if (chg_edge < 0 && mode_chg) chg_edge = e;
    end
    check("t2_db_edge", db_edge, 10);
    check("t2_mode_edge", md_edge, 15);
    check("t2_chg_edge", chg_edge, 15);
    check("t2_chg_count", chg_seen - c0, 1);
    check("t2_valid", {31'd0, mode_valid}, 32'd1);

    // 5: all off from mode 9; mode drops one cycle after sw_db clears
    sw_raw = 10'h000;
    db_edge = -1; md_edge = -1; chg_edge = -1; c0 = chg_seen;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (db_edge < 0 && sw_db == 10'h000) db_edge = e;
      if (md_edge < 0 && mode == 4'hA) md_edge = e;
      if (chg_edge < 0 && mode_chg) chg_edge = e;
    end
    check("t5_db_edge", db_edge, 10);
    check("t5_mode_edge", md_edge, 11);
    check("t5_chg_edge", chg_edge, 11);
    check("t5_chg_count", chg_seen - c0, 1);
    check("t5_valid", {31'd0, mode_valid}, 32'd0);

    // 3, 4, 6: table of steps {sw_raw, cycles, sw_db, mode, valid, interlock, pulses}
    vecs[0]  = '{10'h200, 30, 10'h200, 4'd9, 1'b1, 1'b0, 1};
    vecs[1]  = '{10'h208,  5, 10'h200, 4'd9, 1'b1, 1'b0, 0};
    vecs[2]  = '{10'h200, 30, 10'h200, 4'd9, 1'b1, 1'b0, 0};
    vecs[3]  = '{10'h000, 30, 10'h000, 4'hA, 1'b0, 1'b0, 1};
    vecs[4]  = '{10'h048, 30, 10'h048, 4'd6, 1'b1, 1'b0, 1};
    vecs[5]  = '{10'h008, 30, 10'h008, LOCK_EN ? 4'hA : 4'd3, ~LOCK_EN, LOCK_EN, 1};
    vecs[6]  = '{10'h000, 30, 10'h000, 4'hA, 1'b0, 1'b0, LOCK_EN ? 0 : 1};
    vecs[7]  = '{10'h200, 30, 10'h200, 4'd9, 1'b1, 1'b0, 1};
    vecs[8]  = '{10'h100, 30, 10'h100, LOCK_EN ? 4'hA : 4'd8, ~LOCK_EN, LOCK_EN, 1};
    vecs[9]  = '{10'h100, 30, 10'h100, LOCK_EN ? 4'hA : 4'd8, ~LOCK_EN, LOCK_EN, 0};
    vecs[10] = '{10'h000, 30, 10'h000, 4'hA, 1'b0, 1'b0, LOCK_EN ? 0 : 1};
    vecs[11] = '{10'h100, 30, 10'h100, 4'd8, 1'b1, 1'b0, 1};

    for (int v = 0; v < 12; v++) begin
      sw_raw = vecs[v].sw;
      c0 = chg_seen;
      for (int i = 0; i < vecs[v].cycles; i++) tick();
      check($sformatf("vec%0d_sw_db", v), {22'd0, sw_db}, {22'd0, vecs[v].db});
      check($sformatf("vec%0d_mode", v), {28'd0, mode}, {28'd0, vecs[v].mode});
      check($sformatf("vec%0d_valid", v), {31'd0, mode_valid}, {31'd0, vecs[v].valid});
      check($sformatf("vec%0d_interlock", v), {31'd0, interlock}, {31'd0, vecs[v].lock});
      check($sformatf("vec%0d_chg_count", v), chg_seen - c0, vecs[v].chg);
    end

    // 7: reset asserted while in SETTLE
    sw_raw = 10'h000;
    for (int i = 0; i < 30; i++) tick();
    sw_raw = 10'h010;
    c0 = chg_seen;
    for (int i = 0; i < 12; i++) tick();
    check("t7_settle_sw_db", {22'd0, sw_db}, 32'h010);
    check("t7_settle_mode_held", {28'd0, mode}, 32'hA);
    #5 rst = 1'b1;
    #1;
    check("t7_rst_sw_db", {22'd0, sw_db}, 32'd0);
    check("t7_rst_mode", {28'd0, mode}, 32'hA);
    check("t7_rst_valid", {31'd0, mode_valid}, 32'd0);
    check("t7_rst_chg", {31'd0, mode_chg}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t7_no_chg_from_reset", chg_seen - c0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("t7_recover_mode", {28'd0, mode}, 32'd4);
    check("t7_recover_chg", chg_seen - c0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
